// File: rtl/dig_ct_pkg.sv
// Shared constants and per-bit logic functions for the dig_ct pipeline.
package dig_ct_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int STAGES_DEF = 2;
    localparam int CNT_W      = 16;

    function automatic logic ct_out1(input logic a, input logic b, input logic c);
        return ~(~(a | b) & c);
    endfunction

    function automatic logic ct_out2(input logic b, input logic c);
        return ~(b & c);
    endfunction

    function automatic logic ct_out3(input logic c, input logic d, input logic e);
        return ~d | c | e;
    endfunction

endpackage

// File: rtl/dig_ct_slot.sv
// One pipeline register slot: a valid bit plus a data word, both loaded together.
module dig_ct_slot
    import dig_ct_pkg::*;
#(
    parameter int DW = 3 * WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    output logic          valid,
    output logic [DW-1:0] data
);

    // NOTE: state uses <= so every slot samples its neighbour's pre-edge value;
    // the data word is reset too, because downstream sees zeros straight after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= valid_in;
            if (valid_in) begin
                data <= data_in;
            end
        end
    end

endmodule

// File: rtl/dig_ct_pipe.sv
// Three-output bitwise logic block feeding a STAGES-deep valid/ready pipeline.
// Optional macro DIG_CT_PARITY_EN adds out_par (XOR of all result bits).
module dig_ct_pipe
    import dig_ct_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt
`ifdef DIG_CT_PARITY_EN
    ,
    output logic             out_par
`endif
);

`ifdef DIG_CT_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int DW = 3 * WIDTH + PAR_W;

    logic [WIDTH-1:0]  r1, r2, r3;
    logic [DW-1:0]     beat_d;
    logic [STAGES-1:0] slot_v;
    logic [STAGES-1:0] slot_ld;
    logic [DW-1:0]     slot_d [STAGES];

    always_comb begin
        r1 = '0;
        r2 = '0;
        r3 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r1[i] = ct_out1(in1[i], in2[i], in3[i]);
            r2[i] = ct_out2(in2[i], in3[i]);
            r3[i] = ct_out3(in3[i], in4[i], in5[i]);
        end
    end

`ifdef DIG_CT_PARITY_EN
    assign beat_d = {^{r1, r2, r3}, r3, r2, r1};
`else
    assign beat_d = {r3, r2, r1};
`endif

    // Slot k can load iff some slot at or after k is empty, or the consumer takes the last one.
    always_comb begin
        slot_ld = '0;
        for (int k = 0; k < STAGES; k++) begin
            slot_ld[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!slot_v[j]) begin
                    slot_ld[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        logic          v_in;
        logic [DW-1:0] d_in;
        if (k == 0) begin : g_first
            assign v_in = in_valid;
            assign d_in = beat_d;
        end else begin : g_next
            assign v_in = slot_v[k-1];
            assign d_in = slot_d[k-1];
        end
        dig_ct_slot #(.DW(DW)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (slot_ld[k]),
            .valid_in (v_in),
            .data_in  (d_in),
            .valid    (slot_v[k]),
            .data     (slot_d[k])
        );
    end

    assign in_ready          = slot_ld[0];
    assign out_valid         = slot_v[STAGES-1];
    assign {out3, out2, out1} = slot_d[STAGES-1][3*WIDTH-1:0];
`ifdef DIG_CT_PARITY_EN
    assign out_par = slot_d[STAGES-1][DW-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (out_valid && out_ready) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dig_ct_pipe.sv
// Directed self-checking bench for dig_ct_pipe (WIDTH=8, STAGES=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dig_ct_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0, in5 = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid;
    logic [7:0] out1, out2, out3;
    logic [15:0] cnt;
`ifdef DIG_CT_PARITY_EN
    logic       out_par;
`endif

    int total = 0;
    int bad   = 0;

    // Hand-computed vectors: {in1,in2,in3,in4,in5} -> {out1,out2,out3}, parity
    localparam logic [7:0] VEC_IN [4][5] = '{
        '{8'h00, 8'h00, 8'hF0, 8'h0F, 8'h00},
        '{8'hA5, 8'h0F, 8'h3C, 8'h55, 8'h80},
        '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00},
        '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A}
    };
    localparam logic [7:0] VEC_OUT [4][3] = '{
        '{8'h0F, 8'hFF, 8'hF0},
        '{8'hEF, 8'hF3, 8'hBE},
        '{8'h00, 8'hFF, 8'hFF},
        '{8'hBF, 8'hEB, 8'hDF}
    };
    localparam logic VEC_PAR [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    dig_ct_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .in5       (in5),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt       (cnt)
`ifdef DIG_CT_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_tag(input logic [7:0] tag);
        in1 = tag; in2 = 8'h00; in3 = 8'hFF; in4 = 8'hFF; in5 = 8'h00;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (cnt !== 16'h0000) begin bad++; $display("FAIL reset_cnt got=%h exp=0000", cnt); end
        total++; if ({out1, out2, out3} !== 24'h0) begin bad++; $display("FAIL reset_outs got=%h exp=000000", {out1, out2, out3}); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        drive_tag(8'h77);
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_no_accept got=%b exp=0", out_valid); end
        in_valid = 1'b0;
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_post_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_logic();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in1 = VEC_IN[i][0]; in2 = VEC_IN[i][1]; in3 = VEC_IN[i][2];
            in4 = VEC_IN[i][3]; in5 = VEC_IN[i][4];
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL logic%0d_early got=%b exp=0", i, out_valid); end
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL logic%0d_valid got=%b exp=1", i, out_valid); end
            total++; if (out1 !== VEC_OUT[i][0]) begin bad++; $display("FAIL logic%0d_out1 got=%h exp=%h", i, out1, VEC_OUT[i][0]); end
            total++; if (out2 !== VEC_OUT[i][1]) begin bad++; $display("FAIL logic%0d_out2 got=%h exp=%h", i, out2, VEC_OUT[i][1]); end
            total++; if (out3 !== VEC_OUT[i][2]) begin bad++; $display("FAIL logic%0d_out3 got=%h exp=%h", i, out3, VEC_OUT[i][2]); end
`ifdef DIG_CT_PARITY_EN
            total++; if (out_par !== VEC_PAR[i]) begin bad++; $display("FAIL logic%0d_par got=%b exp=%b", i, out_par, VEC_PAR[i]); end
`endif
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL logic%0d_one_cycle got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int seen = 0;
        int last_cyc = 0;
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (out_valid) begin
                total++; if (out1 !== 8'(seen)) begin bad++; $display("FAIL b2b_order got=%h exp=%h", out1, 8'(seen)); end
                if (seen > 0) begin
                    total++; if (cyc !== last_cyc + 1) begin bad++; $display("FAIL b2b_gap got=%0d exp=%0d", cyc, last_cyc + 1); end
                end
                seen++;
                last_cyc = cyc;
            end
            if (sent < 8) begin
                drive_tag(8'(sent));
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        total++; if (seen !== 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", seen); end
        total++; if (cnt !== 16'd8) begin bad++; $display("FAIL b2b_cnt got=%0d exp=8", cnt); end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        int seen = 0;
        logic [7:0] tag = 8'h21;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) begin
                total++; if (out1 !== 8'h21) begin bad++; $display("FAIL bp_stable got=%h exp=21", out1); end
            end
            drive_tag(tag);
            if (in_ready) begin
                accepted++;
                tag++;
            end
        end
        @(negedge clk);
        total++; if (accepted !== 2) begin bad++; $display("FAIL bp_accepts got=%0d exp=2", accepted); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
        total++; if (cnt !== 16'd0) begin bad++; $display("FAIL bp_cnt_stalled got=%0d exp=0", cnt); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid) begin
                total++; if (out1 !== 8'(8'h21 + seen)) begin bad++; $display("FAIL bp_order got=%h exp=%h", out1, 8'(8'h21 + seen)); end
                seen++;
            end
        end
        total++; if (seen !== 2) begin bad++; $display("FAIL bp_delivered got=%0d exp=2", seen); end
        total++; if (cnt !== 16'd2) begin bad++; $display("FAIL bp_cnt got=%0d exp=2", cnt); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b1;
        drive_tag(8'h40);
        @(negedge clk); drive_tag(8'h41);
        @(negedge clk); drive_tag(8'h42);
        @(negedge clk); in_valid = 1'b0;
        total++; if (cnt !== 16'd1) begin bad++; $display("FAIL mid_cnt_pre got=%0d exp=1", cnt); end
        total++; if (out_valid !== 1'b1 || out1 !== 8'h41) begin bad++; $display("FAIL mid_pre got=%b/%h exp=1/41", out_valid, out1); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        total++; if (cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", cnt); end
        total++; if (out1 !== 8'h00) begin bad++; $display("FAIL mid_out1 got=%h exp=00", out1); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        drive_tag(8'h55);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready got=%b exp=1", in_ready); end
        drive_tag(8'h46);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_latency1 got=%b exp=0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out1 !== 8'h46) begin bad++; $display("FAIL mid_next_beat got=%b/%h exp=1/46", out_valid, out1); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_drained got=%b exp=0", out_valid); end
        total++; if (cnt !== 16'd1) begin bad++; $display("FAIL mid_cnt_post got=%0d exp=1", cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        drive_tag(8'h99);
        repeat (65537) @(negedge clk);
        in_valid = 1'b0;
        total++; if (cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff got=%h exp=ffff", cnt); end
        @(negedge clk);
        total++; if (cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", cnt); end
        @(negedge clk);
        total++; if (cnt !== 16'h0001) begin bad++; $display("FAIL wrap_one got=%h exp=0001", cnt); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || cnt !== 16'h0001) begin bad++; $display("FAIL wrap_idle got=%b/%h exp=0/0001", out_valid, cnt); end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
